// File: rtl/tri_mat_row_server_if.sv
// Bus bundle for tri_mat_row_server: element write stream, row read request/response,
// and flush/status. The master modport drives the stream side; the slave modport is the server.
interface tri_mat_row_server_if #(
    parameter int SIZE = 16
);
    localparam int AW = $clog2(SIZE);

    logic [127:0]         wr_data_i;
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [AW-1:0]        rd_addr_i;
    logic                 rd_addr_valid_i;
    logic [SIZE*128-1:0]  row_o;
    logic [AW-1:0]        row_addr_o;
    logic                 row_valid_o;
    logic                 flush_i;
    logic                 load_done_o;
    logic                 busy_o;

    modport master (
        output wr_data_i, wr_valid_i, rd_addr_i, rd_addr_valid_i, flush_i,
        input  wr_ready_o, row_o, row_addr_o, row_valid_o, load_done_o, busy_o
    );

    modport slave (
        input  wr_data_i, wr_valid_i, rd_addr_i, rd_addr_valid_i, flush_i,
        output wr_ready_o, row_o, row_addr_o, row_valid_o, load_done_o, busy_o
    );
endinterface

// File: rtl/tri_mat_row_server.sv
// SIZE x SIZE complex-double matrix, loaded as a row-major element stream and served one full row per cycle.
// Optional macro TRI_ZERO_FILL_EN: stream carries only the lower triangle (c <= r); upper elements read as zero.
module tri_mat_row_server #(
    parameter int SIZE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tri_mat_row_server_if.slave  bus
);
    localparam int AW = $clog2(SIZE);
    localparam int RW = SIZE * 128;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_row;
    logic [AW-1:0]   r_col;
    logic [RW-1:0]   r_mem [SIZE];
    logic [RW-1:0]   r_row_out;
    logic [AW-1:0]   r_row_addr;
    logic            r_row_valid;
    logic            r_load_done;

    logic            w_accept;
    logic            w_last_col;
    logic            w_last_elem;
    logic            w_rd_fire;
    logic [RW-1:0]   w_rd_row;

    assign w_accept  = bus.wr_valid_i && (r_state != READY);
    assign w_rd_fire = bus.rd_addr_valid_i && (r_state == READY);

`ifdef TRI_ZERO_FILL_EN
    // Triangular rows end on the diagonal.
    assign w_last_col = (r_col == r_row);
`else
    assign w_last_col = (r_col == AW'(SIZE - 1));
`endif
    assign w_last_elem = w_last_col && (r_row == AW'(SIZE - 1));

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush_i) begin
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY:   if (w_accept) w_state_nxt = w_last_elem ? READY : LOAD;
                LOAD:    if (w_accept && w_last_elem) w_state_nxt = READY;
                READY:   w_state_nxt = READY;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_elem ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // NOTE: storage is cleared on reset and flush because a reloaded matrix must never expose stale elements.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            for (int r = 0; r < SIZE; r++) begin
                r_mem[r] <= '0;
            end
        end else if (w_accept) begin
            r_mem[r_row][int'(r_col)*128 +: 128] <= bus.wr_data_i;
        end
    end

    always_comb begin
        w_rd_row = r_mem[bus.rd_addr_i];
`ifdef TRI_ZERO_FILL_EN
        for (int c = 0; c < SIZE; c++) begin
            if (c > int'(bus.rd_addr_i)) begin
                w_rd_row[c*128 +: 128] = '0;
            end
        end
`endif
    end

    // Row data and address hold between requests; only the qualifiers drop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_row_out   <= '0;
            r_row_addr  <= '0;
            r_row_valid <= 1'b0;
            r_load_done <= 1'b0;
        end else if (bus.flush_i) begin
            r_row_valid <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_accept && w_last_elem;
            r_row_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_row_out  <= w_rd_row;
                r_row_addr <= bus.rd_addr_i;
            end
        end
    end

    assign bus.wr_ready_o  = (r_state != READY);
    assign bus.busy_o      = (r_state == LOAD);
    assign bus.load_done_o = r_load_done;
    assign bus.row_valid_o = r_row_valid;
    assign bus.row_addr_o  = r_row_addr;
    assign bus.row_o       = r_row_out;
endmodule

// File: tb/tb_tri_mat_row_server.sv
// Scoreboard bench for tri_mat_row_server: loads matrices through the stream port, reads rows,
// and checks flush/reset priority; follows TRI_ZERO_FILL_EN when defined.
module tb_tri_mat_row_server;
    localparam int SIZE = 16;
    localparam int AW   = $clog2(SIZE);
    localparam int RW   = SIZE * 128;
`ifdef TRI_ZERO_FILL_EN
    localparam int NELEM = SIZE * (SIZE + 1) / 2;
    localparam bit TRI   = 1'b1;
`else
    localparam int NELEM = SIZE * SIZE;
    localparam bit TRI   = 1'b0;
`endif

    typedef struct {
        logic [RW-1:0] row;
        logic [AW-1:0] addr;
        int            due;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tri_mat_row_server_if #(.SIZE(SIZE)) bus ();
    tri_mat_row_server #(.SIZE(SIZE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    sb_t          sb_q[$];
    sb_t          mon_e;
    logic [127:0] model [SIZE][SIZE];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    bit           tb_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every response must match the oldest outstanding request, exactly one cycle later.
    always @(negedge clk) begin
        if (bus.row_valid_o === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: row_valid_o=1 row_addr_o=%0d at cycle %0d, required no response", bus.row_addr_o, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.due != cyc || bus.row_addr_o !== mon_e.addr) begin
                    n_err++;
                    $display("FAIL sb_addr: got addr %0d at cycle %0d, required addr %0d at cycle %0d", bus.row_addr_o, cyc, mon_e.addr, mon_e.due);
                end else if (bus.row_o !== mon_e.row) begin
                    n_err++;
                    for (int c = 0; c < SIZE; c++) begin
                        if (bus.row_o[c*128 +: 128] !== mon_e.row[c*128 +: 128]) begin
                            $display("FAIL sb_row: row %0d elem %0d got %h, required %h", mon_e.addr, c, bus.row_o[c*128 +: 128], mon_e.row[c*128 +: 128]);
                            break;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] elem(input int r, input int c, input int seed);
        return {32'(seed), 32'(r), 32'(seed), 32'(c)};
    endfunction

    function automatic void rc_of(input int k, output int r, output int c);
        if (TRI) begin
            r = 0;
            while (k > r) begin
                k -= r + 1;
                r++;
            end
            c = k;
        end else begin
            r = k / SIZE;
            c = k % SIZE;
        end
    endfunction

    function automatic logic [RW-1:0] exp_row(input int a);
        logic [RW-1:0] v;
        for (int c = 0; c < SIZE; c++) v[c*128 +: 128] = model[a][c];
        return v;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                model[r][c] = '0;
        tb_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    // Streams elements [from, to) of the row-major (or triangular) order with wr_valid held high.
    task automatic stream(input int seed, input int from, input int to);
        int r, c;
        for (int k = from; k < to; k++) begin
            rc_of(k, r, c);
            bus.wr_data_i  = elem(r, c, seed);
            bus.wr_valid_i = 1'b1;
            n_vec++;
            if (bus.wr_ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL wr_ready_load: elem %0d wr_ready_o=%b, required 1", k, bus.wr_ready_o);
            end
            model[r][c] = bus.wr_data_i;
            tick();
            n_vec++;
            if (k == NELEM - 1) begin
                tb_ready = 1'b1;
                if (bus.load_done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.wr_ready_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_done: after final accept done/busy/ready=%b%b%b, required 100", bus.load_done_o, bus.busy_o, bus.wr_ready_o);
                end
            end else if (bus.load_done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL load_progress: after elem %0d done/busy=%b%b, required 01", k, bus.load_done_o, bus.busy_o);
            end
        end
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic read_row(input int a);
        sb_t e;
        bus.rd_addr_i       = AW'(a);
        bus.rd_addr_valid_i = 1'b1;
        if (tb_ready) begin
            e.row  = exp_row(a);
            e.addr = AW'(a);
            e.due  = cyc + 1;
            sb_q.push_back(e);
        end
        tick();
        bus.rd_addr_valid_i = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < SIZE; a++) read_row(a);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus.row_valid_o !== 1'b0 || bus.load_done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.row_addr_o !== '0 || bus.row_o !== '0 || bus.wr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: valid/done/busy/ready=%b%b%b%b addr=%0d, required 0001 addr=0 row=0",
                     bus.row_valid_o, bus.load_done_o, bus.busy_o, bus.wr_ready_o, bus.row_addr_o);
        end
    endtask

    task automatic test_full_load();
        logic [127:0] exp27;
        stream(0, 0, NELEM);
        tick();
        n_vec++;
        if (bus.load_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: load_done_o=%b one cycle later, required 0", bus.load_done_o);
        end
        read_row(5);
        n_vec++;
        if (bus.row_valid_o !== 1'b1 || bus.row_addr_o !== AW'(5) || bus.row_o[3*128 +: 128] !== {64'd5, 64'd3}) begin
            n_err++;
            $display("FAIL row5_elem3: valid=%b addr=%0d elem=%h, required 1 5 %h", bus.row_valid_o, bus.row_addr_o, bus.row_o[3*128 +: 128], {64'd5, 64'd3});
        end
        read_row(2);
        exp27 = TRI ? 128'd0 : {64'd2, 64'd7};
        n_vec++;
        if (bus.row_o[1*128 +: 128] !== {64'd2, 64'd1} || bus.row_o[7*128 +: 128] !== exp27) begin
            n_err++;
            $display("FAIL row2_elems: e1=%h e7=%h, required %h %h", bus.row_o[1*128 +: 128], bus.row_o[7*128 +: 128], {64'd2, 64'd1}, exp27);
        end
        read_row(15);
        n_vec++;
        if (bus.row_o[15*128 +: 128] !== {64'd15, 64'd15}) begin
            n_err++;
            $display("FAIL row15_elem15: got %h, required %h", bus.row_o[15*128 +: 128], {64'd15, 64'd15});
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] held;
        read_row(0);
        read_row(15);
        read_row(15);
        read_row(3);
        held = exp_row(3);
        tick();
        n_vec++;
        if (bus.row_valid_o !== 1'b0 || bus.row_addr_o !== AW'(3) || bus.row_o !== held) begin
            n_err++;
            $display("FAIL idle_hold: valid=%b addr=%0d, required valid 0 holding addr 3 and row 3", bus.row_valid_o, bus.row_addr_o);
        end
    endtask

    task automatic test_write_in_ready();
        for (int i = 0; i < 5; i++) begin
            bus.wr_data_i  = {$urandom, $urandom, $urandom, $urandom};
            bus.wr_valid_i = 1'b1;
            n_vec++;
            if (bus.wr_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL wr_ready_ready: wr_ready_o=%b in READY, required 0", bus.wr_ready_o);
            end
            tick();
        end
        bus.wr_valid_i = 1'b0;
        read_all();
    endtask

    task automatic test_read_during_load();
        do_reset();
        stream(0, 0, 40);
        bus.rd_addr_i       = AW'(7);
        bus.rd_addr_valid_i = 1'b1;
        stream(0, 40, 41);
        bus.rd_addr_valid_i = 1'b0;
        n_vec++;
        if (bus.row_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL read_in_load: row_valid_o=%b, required 0", bus.row_valid_o);
        end
        stream(0, 41, NELEM);
        read_row(4);
        read_row(SIZE - 1);
    endtask

    task automatic test_flush();
        int r, c;
        bus.flush_i         = 1'b1;
        bus.rd_addr_i       = AW'(1);
        bus.rd_addr_valid_i = 1'b1;
        tick();
        bus.flush_i         = 1'b0;
        bus.rd_addr_valid_i = 1'b0;
        clear_model();
        n_vec++;
        if (bus.row_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.wr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready: valid/busy/ready=%b%b%b, required 001", bus.row_valid_o, bus.busy_o, bus.wr_ready_o);
        end
        stream(2, 0, 100);
        rc_of(100, r, c);
        bus.wr_data_i       = elem(r, c, 2);
        bus.wr_valid_i      = 1'b1;
        bus.flush_i         = 1'b1;
        bus.rd_addr_valid_i = 1'b1;
        tick();
        bus.wr_valid_i      = 1'b0;
        bus.flush_i         = 1'b0;
        bus.rd_addr_valid_i = 1'b0;
        clear_model();
        n_vec++;
        if (bus.busy_o !== 1'b0 || bus.wr_ready_o !== 1'b1 || bus.row_valid_o !== 1'b0 || bus.load_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_load: busy/ready/valid/done=%b%b%b%b, required 0100", bus.busy_o, bus.wr_ready_o, bus.row_valid_o, bus.load_done_o);
        end
        stream(1, 0, NELEM);
        read_row(6);
        n_vec++;
        if (bus.row_o[6*128 +: 128] !== elem(6, 6, 1)) begin
            n_err++;
            $display("FAIL flush_reload: row6 elem6 got %h, required %h", bus.row_o[6*128 +: 128], elem(6, 6, 1));
        end
        read_all();
    endtask

    task automatic test_reset_mid_load();
        int r, c;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        clear_model();
        stream(3, 0, 17);
        rc_of(17, r, c);
        bus.wr_data_i       = elem(r, c, 3);
        bus.wr_valid_i      = 1'b1;
        bus.flush_i         = 1'b1;
        bus.rd_addr_valid_i = 1'b1;
        rst                 = 1'b1;
        tick();
        rst                 = 1'b0;
        bus.wr_valid_i      = 1'b0;
        bus.flush_i         = 1'b0;
        bus.rd_addr_valid_i = 1'b0;
        clear_model();
        n_vec++;
        if (bus.row_valid_o !== 1'b0 || bus.load_done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.row_addr_o !== '0 || bus.row_o !== '0) begin
            n_err++;
            $display("FAIL reset_mid_load: valid/done/busy=%b%b%b addr=%0d, required 000 addr=0 row=0",
                     bus.row_valid_o, bus.load_done_o, bus.busy_o, bus.row_addr_o);
        end
        stream(4, 0, NELEM);
        read_all();
    endtask

    initial begin
        bus.wr_data_i       = '0;
        bus.wr_valid_i      = 1'b0;
        bus.rd_addr_i       = '0;
        bus.rd_addr_valid_i = 1'b0;
        bus.flush_i         = 1'b0;
        test_reset();
        test_full_load();
        test_back_to_back();
        test_write_in_ready();
        test_flush();
        test_read_during_load();
        test_reset_mid_load();
        tick();
        tick();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
